// File: rtl/rp8_io_timer_pkg.sv
// rtl/rp8_io_timer_pkg.sv - register offsets, TCR layout and clock-select decode for rp8_io_timer
package rp8_io_timer_pkg;

  localparam logic [1:0] OFF_TCR  = 2'd0;
  localparam logic [1:0] OFF_TCNT = 2'd1;
  localparam logic [1:0] OFF_OCR  = 2'd2;
  localparam logic [1:0] OFF_TIFR = 2'd3;

  localparam int TCR_EN   = 0;
  localparam int TCR_CS   = 1;
  localparam int TCR_CTC  = 4;
  localparam int TCR_OVIE = 6;
  localparam int TCR_OCIE = 7;

  localparam int TIFR_OVF = 0;
  localparam int TIFR_OCF = 1;

  typedef struct packed {
    logic       ocie;
    logic       ovie;
    logic       rsv;
    logic       ctc;
    logic [2:0] cs;
    logic       en;
  } tcr_t;

  // Zero marks the reserved selects, which stop the timer.
  function automatic logic [10:0] cs2div(input logic [2:0] cs);
    case (cs)
      3'd0:    return 11'd1;
      3'd1:    return 11'd8;
      3'd2:    return 11'd64;
      3'd3:    return 11'd256;
      3'd4:    return 11'd1024;
      default: return 11'd0;
    endcase
  endfunction

endpackage

// File: rtl/rp8_io_timer_if.sv
// rtl/rp8_io_timer_if.sv - rp8 I/O bus and interrupt handshake between core and timer
interface rp8_io_timer_if;

  logic       io_wen;
  logic       io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt;
  logic [7:0] io_msk;
  logic [7:0] io_rdt;
  logic [1:0] irq_req;
  logic [1:0] irq_ack;

  modport master (
    output io_wen, io_ren, io_adr, io_wdt, io_msk, irq_ack,
    input  io_rdt, irq_req
  );

  modport slave (
    input  io_wen, io_ren, io_adr, io_wdt, io_msk, irq_ack,
    output io_rdt, irq_req
  );

endinterface

// File: rtl/rp8_io_prescaler.sv
// rtl/rp8_io_prescaler.sv - clock-select prescaler producing one-cycle timer ticks
module rp8_io_prescaler
  import rp8_io_timer_pkg::*;
#(
  parameter int PSW = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       clr,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [PSW-1:0] r_cnt;
  logic [10:0]    w_div;
  logic           w_run;
  logic           w_last;

  assign w_div  = cs2div(cs);
  assign w_run  = ena && (w_div != 11'd0);
  assign w_last = (32'(r_cnt) == (32'(w_div) - 32'd1));
  // No tick in the TCR write cycle, so the first tick lands a full divisor later.
  assign tick   = w_run && !clr && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_run || clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PSW'(1);
    end
  end

endmodule

// File: rtl/rp8_io_timer.sv
// rtl/rp8_io_timer.sv - 8-bit timer/counter responder on the rp8 I/O bus with overflow and compare IRQs
module rp8_io_timer
  import rp8_io_timer_pkg::*;
#(
  parameter logic [5:0] BASE = 6'h30,
  parameter int         PSW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  rp8_io_timer_if.slave bus
);

  tcr_t       r_tcr;
  logic [7:0] r_tcnt;
  logic [7:0] r_ocr;
  logic [7:0] r_rdt;
  logic       r_ovf;
  logic       r_ocf;

  logic       w_hit;
  logic       w_wr;
  logic       w_wr_tcr;
  logic       w_wr_tcnt;
  logic       w_wr_ocr;
  logic       w_wr_tifr;
  logic [7:0] w_w1c;
  logic [7:0] w_tifr;
  logic [7:0] w_rmux;
  logic       w_tick;
  logic       w_eq;
  logic       w_ctc_clr;
  logic       w_set_ovf;
  logic       w_set_ocf;
  logic       w_clr_ovf;
  logic       w_clr_ocf;

  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] wdt,
                                       input logic [7:0] msk);
    return (wdt & msk) | (old & ~msk);
  endfunction

  assign w_hit     = (bus.io_adr[5:2] == BASE[5:2]);
  assign w_wr      = w_hit && bus.io_wen;
  assign w_wr_tcr  = w_wr && (bus.io_adr[1:0] == OFF_TCR);
  assign w_wr_tcnt = w_wr && (bus.io_adr[1:0] == OFF_TCNT);
  assign w_wr_ocr  = w_wr && (bus.io_adr[1:0] == OFF_OCR);
  assign w_wr_tifr = w_wr && (bus.io_adr[1:0] == OFF_TIFR);
  assign w_w1c     = bus.io_wdt & bus.io_msk;

  rp8_io_prescaler #(.PSW(PSW)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .ena  (r_tcr[TCR_EN]),
    .clr  (w_wr_tcr),
    .cs   (r_tcr[TCR_CS +: 3]),
    .tick (w_tick)
  );

  // A CPU write to TCNT overrides everything the tick would have done, flags included.
  assign w_eq      = (r_tcnt == r_ocr);
  assign w_ctc_clr = r_tcr[TCR_CTC] && w_eq;
  assign w_set_ocf = w_tick && !w_wr_tcnt && w_eq;
  assign w_set_ovf = w_tick && !w_wr_tcnt && !w_ctc_clr && (r_tcnt == 8'hFF);
  assign w_clr_ovf = (w_wr_tifr && w_w1c[TIFR_OVF]) || bus.irq_ack[0];
  assign w_clr_ocf = (w_wr_tifr && w_w1c[TIFR_OCF]) || bus.irq_ack[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcr  <= '0;
      r_tcnt <= 8'h00;
      r_ocr  <= 8'h00;
    end else begin
      if (w_wr_tcr) begin
        r_tcr <= tcr_t'(merge(r_tcr, bus.io_wdt, bus.io_msk));
      end
      if (w_wr_ocr) begin
        r_ocr <= merge(r_ocr, bus.io_wdt, bus.io_msk);
      end
      if (w_wr_tcnt) begin
        r_tcnt <= merge(r_tcnt, bus.io_wdt, bus.io_msk);
      end else if (w_tick) begin
        r_tcnt <= w_ctc_clr ? 8'h00 : r_tcnt + 8'h01;
      end
    end
  end

  // Hardware set takes priority over software clear and acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_ocf <= 1'b0;
    end else begin
      if (w_set_ovf)      r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
      if (w_set_ocf)      r_ocf <= 1'b1;
      else if (w_clr_ocf) r_ocf <= 1'b0;
    end
  end

  always_comb begin
    w_tifr           = 8'h00;
    w_tifr[TIFR_OVF] = r_ovf;
    w_tifr[TIFR_OCF] = r_ocf;
    w_rmux           = 8'h00;
    case (bus.io_adr[1:0])
      OFF_TCR:  w_rmux = r_tcr;
      OFF_TCNT: w_rmux = r_tcnt;
      OFF_OCR:  w_rmux = r_ocr;
      OFF_TIFR: w_rmux = w_tifr;
      default:  w_rmux = 8'h00;
    endcase
  end

  // Zero when not read so several responders can be OR-combined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdt <= 8'h00;
    end else if (w_hit && bus.io_ren) begin
      r_rdt <= w_rmux;
    end else begin
      r_rdt <= 8'h00;
    end
  end

  assign bus.io_rdt  = r_rdt;
  assign bus.irq_req = {r_ocf && r_tcr[TCR_OCIE], r_ovf && r_tcr[TCR_OVIE]};

endmodule

// File: tb/tb_rp8_io_timer.sv
// tb/tb_rp8_io_timer.sv - directed self-checking bench for rp8_io_timer
module tb_rp8_io_timer;

  localparam logic [5:0] BASE = 6'h30;
  localparam logic [1:0] R_TCR  = 2'd0;
  localparam logic [1:0] R_TCNT = 2'd1;
  localparam logic [1:0] R_OCR  = 2'd2;
  localparam logic [1:0] R_TIFR = 2'd3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rp8_io_timer_if bus ();

  rp8_io_timer #(.BASE(BASE), .PSW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wen;
    logic       ren;
    logic [5:0] adr;
    logic [7:0] wdt;
    logic [7:0] msk;
    logic [7:0] exp_rdt;
    logic [1:0] exp_irq;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d, input logic [7:0] m = 8'hFF);
    bus.io_wen = 1'b1;
    bus.io_ren = 1'b0;
    bus.io_adr = BASE | {4'b0000, off};
    bus.io_wdt = d;
    bus.io_msk = m;
    step();
    bus.io_wen = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] off, input logic [7:0] exp);
    bus.io_ren = 1'b1;
    bus.io_adr = BASE | {4'b0000, off};
    step();
    bus.io_ren = 1'b0;
    chk(name, bus.io_rdt, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // wen ren adr wdt msk exp_rdt exp_irq
    vecs[0]  = '{1'b0, 1'b1, 6'h30, 8'h00, 8'h00, 8'h00, 2'b00};
    vecs[1]  = '{1'b0, 1'b1, 6'h31, 8'h00, 8'h00, 8'h00, 2'b00};
    vecs[2]  = '{1'b0, 1'b1, 6'h32, 8'h00, 8'h00, 8'h00, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 6'h33, 8'h00, 8'h00, 8'h00, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 6'h34, 8'h00, 8'h00, 8'h00, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, 6'h32, 8'hA5, 8'hFF, 8'h00, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 6'h32, 8'h00, 8'h00, 8'hA5, 2'b00};
    vecs[7]  = '{1'b1, 1'b1, 6'h32, 8'h3C, 8'h0F, 8'hA5, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 6'h32, 8'h00, 8'h00, 8'hAC, 2'b00};
    vecs[9]  = '{1'b1, 1'b0, 6'h31, 8'h5A, 8'hFF, 8'h00, 2'b00};
    vecs[10] = '{1'b1, 1'b0, 6'h11, 8'hFF, 8'hFF, 8'h00, 2'b00};
    vecs[11] = '{1'b0, 1'b1, 6'h31, 8'h00, 8'h00, 8'h5A, 2'b00};
    vecs[12] = '{1'b1, 1'b0, 6'h33, 8'hFF, 8'hFF, 8'h00, 2'b00};
    vecs[13] = '{1'b0, 1'b1, 6'h33, 8'h00, 8'h00, 8'h00, 2'b00};
    vecs[14] = '{1'b1, 1'b0, 6'h30, 8'h20, 8'hFF, 8'h00, 2'b00};
    vecs[15] = '{1'b0, 1'b1, 6'h30, 8'h00, 8'h00, 8'h20, 2'b00};
    vecs[16] = '{1'b1, 1'b0, 6'h30, 8'h00, 8'hFF, 8'h00, 2'b00};
    vecs[17] = '{1'b0, 1'b1, 6'h35, 8'h00, 8'h00, 8'h00, 2'b00};

    rst         = 1'b1;
    bus.io_wen  = 1'b0;
    bus.io_ren  = 1'b0;
    bus.io_adr  = 6'h00;
    bus.io_wdt  = 8'h00;
    bus.io_msk  = 8'h00;
    bus.irq_ack = 2'b00;
    step();
    step();
    chk("reset_rdt", bus.io_rdt, 8'h00);
    chk("reset_irq", bus.irq_req, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      bus.io_wen = vecs[i].wen;
      bus.io_ren = vecs[i].ren;
      bus.io_adr = vecs[i].adr;
      bus.io_wdt = vecs[i].wdt;
      bus.io_msk = vecs[i].msk;
      step();
      chk($sformatf("vec%0d_rdt", i), bus.io_rdt, vecs[i].exp_rdt);
      chk($sformatf("vec%0d_irq", i), bus.irq_req, vecs[i].exp_irq);
    end
    bus.io_wen = 1'b0;
    bus.io_ren = 1'b0;

    // Divide-by-1 count from enable.
    wr(R_TCNT, 8'h00);
    wr(R_TCR, 8'h01);
    repeat (10) step();
    rd_chk("count10", R_TCNT, 8'h0A);

    // Overflow interrupt and acknowledge.
    wr(R_TCR, 8'h00);
    wr(R_TIFR, 8'h03);
    wr(R_TCNT, 8'hFE);
    wr(R_TCR, 8'h41);
    step();
    chk("ovf_irq_pre", bus.irq_req, 2'b00);
    step();
    chk("ovf_irq", bus.irq_req, 2'b01);
    rd_chk("ovf_tcnt0", R_TCNT, 8'h00);
    bus.irq_ack = 2'b01;
    step();
    bus.irq_ack = 2'b00;
    chk("ack_irq", bus.irq_req, 2'b00);
    rd_chk("ack_tifr", R_TIFR, 8'h00);

    // Clear-on-compare with OCR = 5.
    wr(R_TCR, 8'h00);
    wr(R_TIFR, 8'h03);
    wr(R_TCNT, 8'h00);
    wr(R_OCR, 8'h05);
    wr(R_TCR, 8'h91);
    repeat (5) step();
    chk("ctc_irq_pre", bus.irq_req, 2'b00);
    step();
    chk("ctc_irq", bus.irq_req, 2'b10);
    bus.io_ren = 1'b1;
    bus.io_adr = BASE | 6'd1;
    for (int k = 7; k <= 18; k++) begin
      step();
      chk($sformatf("ctc_seq%0d", k), bus.io_rdt, 32'((k - 1) % 6));
    end
    bus.io_ren = 1'b0;
    repeat (100) step();
    rd_chk("ctc_tifr", R_TIFR, 8'h02);
    chk("ctc_irq_late", bus.irq_req, 2'b10);

    // Divide-by-64, then masked write back to divide-by-1.
    wr(R_TCR, 8'h00);
    wr(R_TIFR, 8'h03);
    wr(R_TCNT, 8'h00);
    wr(R_TCR, 8'h05);
    bus.io_ren = 1'b1;
    bus.io_adr = BASE | 6'd1;
    for (int k = 1; k <= 129; k++) begin
      step();
      if (k == 64)  chk("div64_k64", bus.io_rdt, 8'h00);
      if (k == 65)  chk("div64_k65", bus.io_rdt, 8'h01);
      if (k == 128) chk("div64_k128", bus.io_rdt, 8'h01);
      if (k == 129) chk("div64_k129", bus.io_rdt, 8'h02);
    end
    bus.io_ren = 1'b0;
    wr(R_TCR, 8'h00, 8'h0E);
    bus.io_ren = 1'b1;
    bus.io_adr = BASE | 6'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("div1_rate%0d", k), bus.io_rdt, 32'(2 + k));
    end
    bus.io_ren = 1'b0;
    rd_chk("masked_tcr", R_TCR, 8'h01);

    // TCNT write on a tick (and on a compare match) wins.
    wr(R_TCR, 8'h00);
    wr(R_TIFR, 8'h03);
    wr(R_TCNT, 8'h05);
    wr(R_TCR, 8'h01);
    wr(R_TCNT, 8'h10);
    rd_chk("tick_wr_tcnt", R_TCNT, 8'h10);
    rd_chk("tick_wr_noocf", R_TIFR, 8'h00);

    // OVF set beats a same-cycle write-1-to-clear.
    wr(R_TCR, 8'h00);
    wr(R_TIFR, 8'h03);
    wr(R_TCNT, 8'hFE);
    wr(R_TCR, 8'h01);
    step();
    wr(R_TIFR, 8'h01);
    rd_chk("set_beats_clr", R_TIFR, 8'h01);
    wr(R_TIFR, 8'h01);
    rd_chk("w1c_clears", R_TIFR, 8'h00);

    // Asynchronous reset mid-count.
    wr(R_TIFR, 8'h03);
    wr(R_TCR, 8'hC1);
    wr(R_TCNT, 8'hFF);
    step();
    chk("pre_rst_irq", bus.irq_req, 2'b01);
    rd_chk("pre_rst_tcr", R_TCR, 8'hC1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rdt", bus.io_rdt, 8'h00);
    chk("async_rst_irq", bus.irq_req, 2'b00);
    step();
    #3;
    rst = 1'b0;
    step();
    rd_chk("post_rst_tcr", R_TCR, 8'h00);
    rd_chk("post_rst_tcnt", R_TCNT, 8'h00);
    rd_chk("post_rst_ocr", R_OCR, 8'h00);
    rd_chk("post_rst_tifr", R_TIFR, 8'h00);
    repeat (5) step();
    rd_chk("post_rst_stopped", R_TCNT, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rp8_io_timer.md
Name: rp8_io_timer

Overview:
- 8-bit timer/counter peripheral; a responder on the rp8 I/O peripheral bus, driven by the core as initiator.
- Occupies 4 consecutive I/O addresses starting at BASE.
- Drives two interrupt request lines into the core's irq_req/irq_ack handshake: overflow and compare-match.
- Read data is zero when the block is not selected, so several peripherals can be OR-combined onto io_rdt.

Parameters:
- BASE, 6'h30, I/O address of register 0; must be 4-aligned.
- PSW, 10, prescaler counter width; must be at least 10 to support divide-by-1024.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- io_wen  in  1  write enable
- io_ren  in  1  read enable
- io_adr  in  6  register address
- io_wdt  in  8  write data
- io_msk  in  8  write bit mask; 1 = bit is written
- io_rdt  out  8  read data, registered
- irq_req  out  2  interrupt requests: [0] overflow, [1] compare
- irq_ack  in  2  interrupt acknowledge, one-cycle pulse per line

Behaviour:
- Register map, offset from BASE:
  - 0 TCR: [0] EN, [3:1] CS (clock select), [4] CTC (clear on compare), [6] OVIE, [7] OCIE.
  - 1 TCNT: counter value.
  - 2 OCR: compare value.
  - 3 TIFR: [0] OVF, [1] OCF, other bits read 0; write-1-to-clear.
- Hit condition: io_adr[5:2] == BASE[5:2].
- Write on hit with io_wen: reg <= io_wdt & io_msk | reg & ~io_msk.
  - TIFR exception: a flag clears where io_wdt & io_msk is 1.
- Read on hit with io_ren: io_rdt <= reg in the next cycle (1-cycle latency).
  - Without a hit read, io_rdt <= 0 every cycle.
  - Reads have no side effects.
- Write and read of the same register in the same cycle: io_rdt returns the old value.
- Prescaler:
  - Counts up while EN=1 and CS is in 0..4.
  - Divisors for CS 0..4: 1, 8, 64, 256, 1024. CS 5..7 are reserved: timer stopped, prescaler held at 0.
  - Emits a one-cycle tick when the count reaches divisor-1, then restarts at 0.
  - Held at 0 while EN=0, or in the cycle TCR is written.
- On tick:
  - eq = (TCNT == OCR). If eq, set OCF.
  - If CTC & eq: TCNT <= 0.
  - Else: TCNT <= TCNT+1, wrapping 8'hFF -> 8'h00. The wrap sets OVF.
  - When CTC & eq & TCNT==8'hFF, TCNT clears and OVF is not set.
- CPU write to TCNT in the same cycle as a tick: the write wins; the tick's increment and flag setting are discarded.
- Flag hardware set versus software clear or irq_ack in the same cycle: set wins.
- irq_req[0] = OVF & OVIE; irq_req[1] = OCF & OCIE. Both are combinational from registers.
- irq_ack[i] clears flag i in the next cycle.
  - An ack while the flag is clear has no effect.
- Reset (asynchronous, any time, including mid-count):
  - All registers, the prescaler and io_rdt go to 0; irq_req = 0.
  - The first tick after EN is set arrives divisor cycles after the TCR write.

Decomposition:
- Package rp8_io_timer_pkg holds:
  - register offset constants (TCR, TCNT, OCR, TIFR);
  - TCR bit-position constants;
  - a packed struct for TCR;
  - a function cs2div(CS) returning the divisor, 0 = stopped.
- Sub-module rp8_io_prescaler:
  - Inputs: clk, rst, ena, clr, cs.
  - Output: tick.
  - Contains the PSW-bit counter and the divisor compare.
- The top level holds the register file, bus decode, counter/compare logic and the interrupt flags.

Test Plan:
- Reset, then read all 4 registers → io_rdt = 8'h00 each, one cycle after io_ren. A read at BASE+4 → 8'h00.
- Write TCR = 8'h01 (EN, CS=0), wait 10 cycles, read TCNT → 8'h0A (±1 for the read-latency alignment, exact value checked against the reference model).
- TCNT = 8'hFE, TCR = 8'h41 (OVIE, EN, CS=0) → irq_req[0] rises 2 ticks later with TCNT = 8'h00. Pulse irq_ack[0] → irq_req[0] falls the next cycle and TIFR reads 8'h00.
- OCR = 8'h05, TCR = 8'h91 (OCIE, CTC, EN) → TCNT sequence 0..5,0,...; irq_req[1] asserts at the first match; OVF never sets over 100 cycles.
- TCR = 8'h05 (CS=2, divide-by-64) → TCNT increments exactly every 64 cycles. Masked write io_msk = 8'h0E, io_wdt = 8'h00 → CS cleared to 0, EN remains 1, and the count rate becomes 1 per cycle.
- Simultaneous events:
  - TCNT write of 8'h10 on a tick cycle → TCNT reads 8'h10.
  - TIFR write-1-clear in the same cycle as an OVF set → OVF stays 1.
  - rst asserted mid-count → every output is 0 immediately, without waiting for a clock edge.
